// File: rtl/square_motion_pkg.sv
// Shared constants for the bouncing-squares motion engine: init tables, base speeds,
// position widths, FSM encoding and LFSR constants (entries 4..7 cover larger NUM_SQ builds).
package square_motion_pkg;

  localparam int X_W    = 11;
  localparam int Y_W    = 10;
  localparam int SPD_W  = 5;
  localparam int MAX_SQ = 8;

  localparam logic [X_W-1:0] INIT_X [MAX_SQ] =
    '{11'd0, 11'd120, 11'd100, 11'd40, 11'd200, 11'd300, 11'd400, 11'd500};
  localparam logic [Y_W-1:0] INIT_Y [MAX_SQ] =
    '{10'd300, 10'd300, 10'd400, 10'd200, 10'd50, 10'd150, 10'd250, 10'd350};
  localparam logic INIT_DIRX [MAX_SQ] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic INIT_DIRY [MAX_SQ] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  localparam logic [SPD_W-1:0] VX [MAX_SQ] =
    '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  localparam logic [SPD_W-1:0] VY [MAX_SQ] =
    '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h5A;

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

endpackage

// File: rtl/bounce_axis.sv
// Single-axis wall-bounce step: next position and direction for one square on one axis.
// Purely combinational; a guard bit on the adder makes the upper-wall compare overflow-free.
module bounce_axis #(
  parameter int W     = 11,
  parameter int MAX   = 560,
  parameter int SPD_W = 5
) (
  input  logic [W-1:0]     pos,
  input  logic             dir,
  input  logic [SPD_W-1:0] spd,
  output logic [W-1:0]     nxt_pos,
  output logic             nxt_dir
);

  localparam int WG = W + 1;
  localparam logic [WG-1:0] MAX_G = WG'(MAX);

  logic [WG-1:0] spd_g;
  logic [WG-1:0] sum;

  assign spd_g = WG'(spd);
  assign sum   = {1'b0, pos} + spd_g;

  always_comb begin
    nxt_pos = pos;
    nxt_dir = dir;
    if (dir) begin
      if (sum >= MAX_G) begin
        nxt_pos = W'(MAX);
        nxt_dir = 1'b0;
      end else begin
        nxt_pos = sum[W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= spd_g) begin
        nxt_pos = '0;
        nxt_dir = 1'b1;
      end else begin
        nxt_pos = pos - spd_g[W-1:0];
      end
    end
  end

endmodule

// File: rtl/square_motion_engine.sv
// Per-frame square motion: on vsync rise, steps one square per clock into shadow regs, then commits all at once.
// Latency NUM_SQ+2 clocks from edge to frame_done; no backpressure, edges while busy are dropped and flagged in overrun.
// Define MOTION_LFSR_EN to add LFSR speed jitter on every bounce.
module square_motion_engine
  import square_motion_pkg::*;
#(
  parameter int NUM_SQ  = 4,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int SQ_SIZE = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  pause,
  output logic [NUM_SQ*X_W-1:0] x_pos_flat,
  output logic [NUM_SQ*Y_W-1:0] y_pos_flat,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDX_W = (NUM_SQ > 1) ? $clog2(NUM_SQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SQ - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic vsync_q, vs_edge;

  logic [X_W-1:0] sx [NUM_SQ];
  logic [Y_W-1:0] sy [NUM_SQ];
  logic           sdx [NUM_SQ];
  logic           sdy [NUM_SQ];

  logic [SPD_W-1:0] cur_vx, cur_vy;
  logic [X_W-1:0]   nx_pos;
  logic [Y_W-1:0]   ny_pos;
  logic             nx_dir, ny_dir;

  assign vs_edge = vsync & ~vsync_q;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_edge && !pause) state_nxt = UPDATE;
      UPDATE:  if (idx == LAST_IDX) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  bounce_axis #(.W(X_W), .MAX(H_RES - SQ_SIZE), .SPD_W(SPD_W)) u_bounce_x (
    .pos(sx[idx]), .dir(sdx[idx]), .spd(cur_vx), .nxt_pos(nx_pos), .nxt_dir(nx_dir)
  );

  bounce_axis #(.W(Y_W), .MAX(V_RES - SQ_SIZE), .SPD_W(SPD_W)) u_bounce_y (
    .pos(sy[idx]), .dir(sdy[idx]), .spd(cur_vy), .nxt_pos(ny_pos), .nxt_dir(ny_dir)
  );

`ifdef MOTION_LFSR_EN
  logic [7:0]       lfsr;
  logic [SPD_W-1:0] spd_x [NUM_SQ];
  logic [SPD_W-1:0] spd_y [NUM_SQ];

  assign cur_vx = spd_x[idx];
  assign cur_vy = spd_y[idx];

  // Jitter is re-derived from the base speed on each bounce, so speeds stay bounded.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      for (int i = 0; i < NUM_SQ; i++) begin
        spd_x[i] <= VX[i];
        spd_y[i] <= VY[i];
      end
    end else if (state == UPDATE) begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      if (nx_dir != sdx[idx]) spd_x[idx] <= VX[idx] + SPD_W'(lfsr[1:0]);
      if (ny_dir != sdy[idx]) spd_y[idx] <= VY[idx] + SPD_W'(lfsr[1:0]);
    end
  end
`else
  assign cur_vx = VX[idx];
  assign cur_vy = VY[idx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      vsync_q    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_SQ; i++) begin
        sx[i]  <= INIT_X[i];
        sy[i]  <= INIT_Y[i];
        sdx[i] <= INIT_DIRX[i];
        sdy[i] <= INIT_DIRY[i];
        x_pos_flat[X_W*i +: X_W] <= INIT_X[i];
        y_pos_flat[Y_W*i +: Y_W] <= INIT_Y[i];
      end
    end else begin
      state      <= state_nxt;
      vsync_q    <= vsync;
      frame_done <= (state == COMMIT);
      if (vs_edge && busy) overrun <= 1'b1;
      case (state)
        IDLE: idx <= '0;
        UPDATE: begin
          sx[idx]  <= nx_pos;
          sy[idx]  <= ny_pos;
          sdx[idx] <= nx_dir;
          sdy[idx] <= ny_dir;
          idx      <= idx + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_SQ; i++) begin
            x_pos_flat[X_W*i +: X_W] <= sx[i];
            y_pos_flat[Y_W*i +: Y_W] <= sy[i];
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_square_motion_engine.sv
// Directed bench for square_motion_engine (default build, NUM_SQ=4).
module tb_square_motion_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        pause;
  logic [43:0] x_pos_flat;
  logic [39:0] y_pos_flat;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  square_motion_engine dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause),
    .x_pos_flat(x_pos_flat), .y_pos_flat(y_pos_flat),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  function automatic int xs(input int i);
    return int'(x_pos_flat[11*i +: 11]);
  endfunction

  function automatic int ys(input int i);
    return int'(y_pos_flat[10*i +: 10]);
  endfunction

  // One vsync pulse; returns cycles from edge to first frame_done (-1 if none) and pulse count.
  task automatic do_frame(output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    @(negedge clk);
    vsync = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) vsync = 1'b0;
      if (frame_done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset;
    int ex[4] = '{0, 120, 100, 40};
    int ey[4] = '{300, 300, 400, 200};
    reset = 1'b1; vsync = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (xs(i) !== ex[i]) begin
        miscompares++; $display("FAIL reset_x[%0d] got %0d want %0d", i, xs(i), ex[i]);
      end
      vectors++;
      if (ys(i) !== ey[i]) begin
        miscompares++; $display("FAIL reset_y[%0d] got %0d want %0d", i, ys(i), ey[i]);
      end
    end
    vectors++;
    if ({frame_done, busy, overrun} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b want 000", {frame_done, busy, overrun});
    end
  endtask

  task automatic test_first_frames;
    int lat, pulses;
    int ex[4] = '{7, 136, 118, 60};
    int ey[4] = '{312, 286, 392, 218};
    do_frame(lat, pulses);
    vectors++;
    if (lat !== 6 || pulses !== 1) begin
      miscompares++; $display("FAIL f1_latency got lat=%0d pulses=%0d want 6/1", lat, pulses);
    end
    vectors++;
    if (xs(1) !== 128 || ys(1) !== 293) begin
      miscompares++; $display("FAIL f1_sq1 got %0d,%0d want 128,293", xs(1), ys(1));
    end
    vectors++;
    if (xs(0) !== 0) begin
      miscompares++; $display("FAIL f1_sq0_x_clamp got %0d want 0", xs(0));
    end
    vectors++;
    if (ys(2) !== 400) begin
      miscompares++; $display("FAIL f1_sq2_y_clamp got %0d want 400", ys(2));
    end
    do_frame(lat, pulses);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (xs(i) !== ex[i] || ys(i) !== ey[i]) begin
        miscompares++;
        $display("FAIL f2_sq%0d got %0d,%0d want %0d,%0d", i, xs(i), ys(i), ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_pause;
    int lat, pulses;
    int ex[4] = '{7, 136, 118, 60};
    int ey[4] = '{312, 286, 392, 218};
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      do_frame(lat, pulses);
      vectors++;
      if (pulses !== 0) begin
        miscompares++; $display("FAIL pause_frame_done[%0d] got %0d pulses want 0", f, pulses);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (xs(i) !== ex[i] || ys(i) !== ey[i]) begin
        miscompares++;
        $display("FAIL pause_hold_sq%0d got %0d,%0d want %0d,%0d", i, xs(i), ys(i), ex[i], ey[i]);
      end
    end
    pause = 1'b0;
    do_frame(lat, pulses);
    vectors++;
    if (lat !== 6 || xs(0) !== 14 || ys(0) !== 318 || xs(1) !== 144 || ys(1) !== 279 ||
        ys(2) !== 384 || xs(3) !== 70) begin
      miscompares++;
      $display("FAIL unpause_f3 got lat=%0d sq0=%0d,%0d sq1=%0d,%0d y2=%0d x3=%0d want 6 14,318 144,279 384 70",
               lat, xs(0), ys(0), xs(1), ys(1), ys(2), xs(3));
    end
  endtask

  task automatic test_wall_clamp;
    int lat, pulses;
    int bad_lat = 0;
    for (int f = 4; f <= 51; f++) begin
      do_frame(lat, pulses);
      if (lat != 6) bad_lat++;
    end
    vectors++;
    if (bad_lat !== 0) begin
      miscompares++; $display("FAIL run_latency got %0d bad frames want 0", bad_lat);
    end
    vectors++;
    if (xs(3) !== 550) begin
      miscompares++; $display("FAIL f51_sq3_x got %0d want 550", xs(3));
    end
    do_frame(lat, pulses);
    vectors++;
    if (xs(3) !== 560) begin
      miscompares++; $display("FAIL f52_sq3_x_max got %0d want 560", xs(3));
    end
    do_frame(lat, pulses);
    vectors++;
    if (xs(3) !== 550) begin
      miscompares++; $display("FAIL f53_sq3_x_back got %0d want 550", xs(3));
    end
  endtask

  task automatic test_overrun;
    int pulses = 0;
    int lat = -1;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL overrun_pre got %b want 0", overrun);
    end
    @(negedge clk);
    vsync = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) vsync = 1'b0;
      if (k == 2) vsync = 1'b1;
      if (k == 3) vsync = 1'b0;
      if (frame_done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++; $display("FAIL overrun_set got %b want 1", overrun);
    end
    vectors++;
    if (pulses !== 1 || lat !== 6) begin
      miscompares++; $display("FAIL overrun_single_frame got pulses=%0d lat=%0d want 1/6", pulses, lat);
    end
  endtask

  task automatic test_reset_mid_update;
    int pulses = 0;
    int ex[4] = '{0, 120, 100, 40};
    int ey[4] = '{300, 300, 400, 200};
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL midupd_busy got %b want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL midupd_flags got busy=%b overrun=%b want 0/0", busy, overrun);
    end
    for (int k = 0; k < 15; k++) begin
      if (frame_done) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++; $display("FAIL midupd_no_frame got %0d pulses want 0", pulses);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (xs(i) !== ex[i] || ys(i) !== ey[i]) begin
        miscompares++;
        $display("FAIL midupd_init_sq%0d got %0d,%0d want %0d,%0d", i, xs(i), ys(i), ex[i], ey[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_first_frames;
    test_pause;
    test_wall_clamp;
    test_overrun;
    test_reset_mid_update;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
